// File: rtl/mac_neuron_unit_if.sv
// Handshake bundle for one MAC neuron: input (activation, weight) beat stream
// and the held result with its saturation flag.
interface mac_neuron_unit_if #(
    parameter int IN_W  = 16,
    parameter int W_W   = 8,
    parameter int B_W   = 8,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic signed [IN_W-1:0]  act;
    logic signed [W_W-1:0]   weight;
    logic signed [B_W-1:0]   bias;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;

    modport master (
        output in_valid, in_last, act, weight, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_last, act, weight, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_neuron_unit.sv
// One MLP neuron: saturating multiply-accumulate over a beat stream, then
// bias, rescale, optional ReLU and output clamp, held until consumed.
//
// state  | meaning
// ACC    | accepting beats, accumulating products
// FINISH | one cycle: bias, shift, ReLU, clamp into result registers
// HOLD   | result valid, waiting for out_ready
module mac_neuron_unit #(
    parameter int IN_W       = 16,
    parameter int W_W        = 8,
    parameter int B_W        = 8,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 0,
    parameter int RELU       = 0
) (
    input  logic             clk,
    input  logic             reset,
    mac_neuron_unit_if.slave s_if
);
    localparam int PROD_W = IN_W + W_W;
    // Wide enough that product+acc never wraps, even if ACC_W < PROD_W.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam int S_W    = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [S_W-1:0]   OUT_MAX = {{(S_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [S_W-1:0]   OUT_MIN = {{(S_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        FINISH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_acc_ovf;
    logic signed [B_W-1:0]   r_bias;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;

    logic                    w_in_ready;
    logic                    w_beat;
    logic                    w_done;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [SUM_W-1:0] w_acc_sum;
    logic signed [ACC_W-1:0] w_acc_sat;
    logic                    w_acc_clamp;
    logic signed [S_W-1:0]   w_bias_sh;
    logic signed [S_W-1:0]   w_fin_sum;
    logic signed [S_W-1:0]   w_fin_shr;
    logic signed [S_W-1:0]   w_fin_relu;
    logic signed [OUT_W-1:0] w_fin_data;
    logic                    w_out_clamp;

    assign w_prod    = s_if.act * s_if.weight;
    assign w_acc_sum = SUM_W'(r_acc) + SUM_W'(w_prod);

    always_comb begin
        w_acc_clamp = 1'b0;
        w_acc_sat   = w_acc_sum[ACC_W-1:0];
        if (w_acc_sum > ACC_MAX) begin
            w_acc_clamp = 1'b1;
            w_acc_sat   = ACC_MAX[ACC_W-1:0];
        end else if (w_acc_sum < ACC_MIN) begin
            w_acc_clamp = 1'b1;
            w_acc_sat   = ACC_MIN[ACC_W-1:0];
        end
    end

    assign w_bias_sh = S_W'(r_bias) <<< FRAC_SHIFT;
    assign w_fin_sum = S_W'(r_acc) + w_bias_sh;
    assign w_fin_shr = w_fin_sum >>> FRAC_SHIFT;

    // ReLU zeroing is not a saturation event; only the output clamp is.
    always_comb begin
        w_fin_relu = w_fin_shr;
        if ((RELU != 0) && w_fin_shr[S_W-1])
            w_fin_relu = '0;
        w_out_clamp = 1'b0;
        w_fin_data  = w_fin_relu[OUT_W-1:0];
        if (w_fin_relu > OUT_MAX) begin
            w_out_clamp = 1'b1;
            w_fin_data  = OUT_MAX[OUT_W-1:0];
        end else if (w_fin_relu < OUT_MIN) begin
            w_out_clamp = 1'b1;
            w_fin_data  = OUT_MIN[OUT_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = (r_state == ACC);
        w_beat      = w_in_ready & s_if.in_valid;
        w_done      = (r_state == HOLD) & s_if.out_ready;
        case (r_state)
            ACC:     if (w_beat && s_if.in_last) w_state_nxt = FINISH;
            FINISH:  w_state_nxt = HOLD;
            HOLD:    if (w_done) w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ACC;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
            r_bias      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_beat) begin
                        r_acc     <= w_acc_sat;
                        r_acc_ovf <= r_acc_ovf | w_acc_clamp;
                        if (s_if.in_last)
                            r_bias <= s_if.bias;
                    end
                end
                FINISH: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_fin_data;
                    r_out_sat   <= r_acc_ovf | w_out_clamp;
                end
                HOLD: begin
                    if (w_done) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_acc_ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_data  = r_out_data;
    assign s_if.out_sat   = r_out_sat;
endmodule

// File: tb/tb_mac_neuron_unit.sv
// Bench for mac_neuron_unit: three parameterisations share one stimulus bus;
// expected results are queued at issue and compared by a separate monitor.
module tb_mac_neuron_unit;
    logic clk;
    logic reset;

    logic signed [15:0] t_act;
    logic signed [7:0]  t_w;
    logic signed [7:0]  t_bias;
    logic               t_last;
    logic               t_valid;
    logic               t_out_ready;
    int                 sel;

    mac_neuron_unit_if if_def ();
    mac_neuron_unit_if if_relu ();
    mac_neuron_unit_if if_a20 ();

    mac_neuron_unit u_def (.clk(clk), .reset(reset), .s_if(if_def.slave));
    mac_neuron_unit #(.RELU(1), .FRAC_SHIFT(4)) u_relu (.clk(clk), .reset(reset), .s_if(if_relu.slave));
    mac_neuron_unit #(.ACC_W(20)) u_a20 (.clk(clk), .reset(reset), .s_if(if_a20.slave));

    assign if_def.in_valid  = t_valid && (sel == 0);
    assign if_relu.in_valid = t_valid && (sel == 1);
    assign if_a20.in_valid  = t_valid && (sel == 2);
    assign if_def.act  = t_act;   assign if_relu.act  = t_act;   assign if_a20.act  = t_act;
    assign if_def.weight = t_w;   assign if_relu.weight = t_w;   assign if_a20.weight = t_w;
    assign if_def.bias = t_bias;  assign if_relu.bias = t_bias;  assign if_a20.bias = t_bias;
    assign if_def.in_last = t_last; assign if_relu.in_last = t_last; assign if_a20.in_last = t_last;
    assign if_def.out_ready = t_out_ready;
    assign if_relu.out_ready = t_out_ready;
    assign if_a20.out_ready = t_out_ready;

    logic               m_in_ready;
    logic               m_out_valid;
    logic signed [15:0] m_out_data;
    logic               m_out_sat;

    always_comb begin
        m_in_ready  = if_def.in_ready;
        m_out_valid = if_def.out_valid;
        m_out_data  = if_def.out_data;
        m_out_sat   = if_def.out_sat;
        if (sel == 1) begin
            m_in_ready  = if_relu.in_ready;
            m_out_valid = if_relu.out_valid;
            m_out_data  = if_relu.out_data;
            m_out_sat   = if_relu.out_sat;
        end else if (sel == 2) begin
            m_in_ready  = if_a20.in_ready;
            m_out_valid = if_a20.out_valid;
            m_out_data  = if_a20.out_data;
            m_out_sat   = if_a20.out_sat;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int sat;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    task automatic expect_res(input int d, input int s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m_out_valid && t_out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected result", 1, 0);
            end else begin
                e = q.pop_front();
                chk("result data", int'(m_out_data), e.data);
                chk("result sat", int'(m_out_sat), e.sat);
            end
        end
    end

    task automatic beat(input int a, input int w, input int b, input bit last);
        int k;
        t_act   = 16'(a);
        t_w     = 8'(w);
        t_bias  = 8'(b);
        t_last  = last;
        t_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!m_in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!m_in_ready)
            chk("beat accept timeout", 0, 1);
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        t_last  = 1'b0;
    endtask

    task automatic finish_vec();
        int k;
        k = 0;
        @(negedge clk);
        while (!(m_out_valid && t_out_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!(m_out_valid && t_out_ready))
            chk("result timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        t_act = '0; t_w = '0; t_bias = '0; t_last = 1'b0; t_valid = 1'b0;
        t_out_ready = 1'b1;
        sel = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("reset def out_valid", int'(if_def.out_valid), 0);
        chk("reset def out_data", int'(if_def.out_data), 0);
        chk("reset def out_sat", int'(if_def.out_sat), 0);
        chk("reset def in_ready", int'(if_def.in_ready), 1);
        chk("reset relu out_valid", int'(if_relu.out_valid), 0);
        chk("reset a20 out_valid", int'(if_a20.out_valid), 0);
        @(posedge clk);
        #1;

        // Basic dot product with latency and in_ready checks
        expect_res(198, 0);
        beat(100, 3, 0, 0);
        beat(-50, 2, 0, 0);
        beat(7, -1, 5, 1);
        @(negedge clk);
        chk("finish in_ready", int'(m_in_ready), 0);
        chk("finish out_valid", int'(m_out_valid), 0);
        @(negedge clk);
        chk("t+2 out_valid", int'(m_out_valid), 1);
        chk("hold in_ready", int'(m_in_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t+3 in_ready", int'(m_in_ready), 1);
        chk("t+3 out_valid", int'(m_out_valid), 0);
        @(posedge clk);
        #1;

        // Output clamp, positive then negative
        expect_res(32767, 1);
        for (int i = 0; i < 4; i++)
            beat(32767, 127, 0, (i == 3));
        finish_vec();
        expect_res(-32768, 1);
        beat(-32768, 127, 0, 1);
        finish_vec();

        // Backpressure with junk beats offered meanwhile
        t_out_ready = 1'b0;
        expect_res(103, 0);
        beat(10, 10, 3, 1);
        t_valid = 1'b1;
        t_act = 16'($urandom());
        t_w = 8'($urandom());
        t_last = 1'($urandom());
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid", int'(m_out_valid), 1);
            chk("bp out_data", int'(m_out_data), 103);
            chk("bp in_ready", int'(m_in_ready), 0);
            @(posedge clk);
            #1;
            t_act = 16'($urandom());
            t_w = 8'($urandom());
            t_last = 1'($urandom());
        end
        t_valid = 1'b0;
        t_last = 1'b0;
        t_out_ready = 1'b1;
        finish_vec();
        expect_res(6, 0);
        beat(2, 3, 0, 1);
        finish_vec();

        // RELU=1, FRAC_SHIFT=4
        sel = 1;
        expect_res(0, 0);
        beat(-10, 10, 0, 1);
        finish_vec();
        expect_res(17, 0);
        beat(16, 16, 1, 1);
        finish_vec();
        expect_res(0, 0);
        beat(-1, 1, 0, 1);
        finish_vec();

        // Reset mid-vector discards the partial sum
        sel = 0;
        beat(1000, 100, 0, 0);
        beat(1000, 100, 0, 0);
        pulse_reset();
        expect_res(6, 0);
        beat(2, 3, 0, 1);
        finish_vec();

        // Reset during HOLD drops the pending result
        t_out_ready = 1'b0;
        beat(5, 5, 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("hold pre-reset valid", int'(m_out_valid), 1);
        chk("hold pre-reset data", int'(m_out_data), 25);
        @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        chk("hold reset out_valid", int'(m_out_valid), 0);
        chk("hold reset out_data", int'(m_out_data), 0);
        chk("hold reset in_ready", int'(m_in_ready), 1);
        t_out_ready = 1'b1;
        @(posedge clk);
        #1;

        // ACC_W=20: accumulator clamp and sticky flag clearing
        sel = 2;
        expect_res(32767, 1);
        beat(32767, 127, 0, 0);
        beat(-1, 1, 0, 1);
        finish_vec();
        expect_res(1, 0);
        beat(1, 1, 0, 1);
        finish_vec();

        repeat (4) @(negedge clk);
        chk("queue drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
